// File: rtl/decode_exec_pkg.sv
// decode_exec_pkg -- shared definitions for the decode/execute slice.
//   opcode_e   : decoded instruction class as presented on the opcode port
//   alu_op_e   : operation selector for decode_exec_alu
//   wb_sel_e   : writeback source select driven on mem_to_reg
//   OPC11_*    : 11-bit major opcodes matched on inst[31:21]
package decode_exec_pkg;

  typedef enum logic [3:0] {
    OP_INVALID = 4'd0,
    OP_ADDI    = 4'd1,
    OP_ADDS    = 4'd2,
    OP_BLT     = 4'd3,
    OP_B       = 4'd4,
    OP_CBZ     = 4'd5,
    OP_LDUR    = 4'd6,
    OP_LSL     = 4'd7,
    OP_LSR     = 4'd8,
    OP_MUL     = 4'd9,
    OP_STUR    = 4'd10,
    OP_SUBS    = 4'd11
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_PASSB = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU   = 2'd0,
    WB_MEM   = 2'd1,
    WB_MUL   = 2'd2,
    WB_SHIFT = 2'd3
  } wb_sel_e;

  localparam logic [10:0] OPC11_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC11_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC11_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC11_STUR = 11'b11111000000;
  localparam logic [10:0] OPC11_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC11_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC11_MUL  = 11'b10011011000;

endpackage

// File: rtl/decode_exec_alu.sv
// decode_exec_alu -- purely combinational 64-bit ALU.
//   a, b   : 64-bit operands
//   op     : ALU_ADD, ALU_SUB (a + ~b + 1) or ALU_PASSB
//   result : 64-bit result, modulo 2^64
//   flags  : {n, z, v, c}; c is the carry out of bit 63, so after a
//            subtract c=1 means no borrow. v and c are 0 for pass-B.
module decode_exec_alu
  import decode_exec_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  alu_op_e     op,
  output logic [63:0] result,
  output logic [3:0]  flags
);

  logic [63:0] b_eff;
  logic        cin;
  logic [64:0] sum;
  logic        v;
  logic        c;

  always_comb begin
    b_eff = (op == ALU_SUB) ? ~b : b;
    cin   = (op == ALU_SUB);
    sum   = {1'b0, a} + {1'b0, b_eff} + {64'd0, cin};
    if (op == ALU_PASSB) begin
      result = b;
      v      = 1'b0;
      c      = 1'b0;
    end else begin
      result = sum[63:0];
      // Overflow: both adder inputs share a sign that the result lacks.
      v      = (a[63] == b_eff[63]) && (sum[63] != a[63]);
      c      = sum[64];
    end
    flags = {result[63], (result == 64'd0), v, c};
  end

endmodule

// File: rtl/decode_exec.sv
// decode_exec -- single-cycle decode/execute stage for a small ARMv8 subset.
//   clk, rst          : clock, synchronous active-high reset
//   inst              : instruction word for the current pc
//   rf_a, rf_b        : register-file read data for ra_addr / rb_addr
//   pc                : registered program counter
//   opcode            : decoded class (see opcode_e)
//   ra/rb/rd_addr     : register addresses, shamt: shift amount
//   reg_write, mem_write, br_taken : control strobes
//   mem_to_reg        : writeback select (see wb_sel_e)
//   alu_result        : ALU result, also the memory address
//   flags             : registered {n, z, v, c}
// Optional: define DECODE_EXEC_TRACE_EN to print a per-cycle trace line.
module decode_exec
  import decode_exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [63:0] rf_a,
  input  logic [63:0] rf_b,
  output logic [63:0] pc,
  output logic [3:0]  opcode,
  output logic [4:0]  ra_addr,
  output logic [4:0]  rb_addr,
  output logic [4:0]  rd_addr,
  output logic [5:0]  shamt,
  output logic        reg_write,
  output logic        mem_write,
  output logic        br_taken,
  output logic [1:0]  mem_to_reg,
  output logic [63:0] alu_result,
  output logic [3:0]  flags
);

  opcode_e     op;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        set_flags;
  logic [63:0] alu_b;
  logic [3:0]  alu_flags;
  logic [63:0] off19;
  logic [63:0] off26;
  logic [63:0] pc_reg, pc_next;
  logic [3:0]  flags_reg, flags_next;

  // Short-prefix classes are tested before the 11-bit table.
  always_comb begin
    op = OP_INVALID;
    if (inst[31:26] == 6'b000101)                            op = OP_B;
    else if (inst[31:24] == 8'h54 && inst[4:0] == 5'b01011) op = OP_BLT;
    else if (inst[31:24] == 8'hB4)                          op = OP_CBZ;
    else if (inst[31:22] == 10'b1001000100)                 op = OP_ADDI;
    else begin
      case (inst[31:21])
        OPC11_ADDS: op = OP_ADDS;
        OPC11_SUBS: op = OP_SUBS;
        OPC11_LDUR: op = OP_LDUR;
        OPC11_STUR: op = OP_STUR;
        OPC11_LSL:  op = OP_LSL;
        OPC11_LSR:  op = OP_LSR;
        OPC11_MUL:  op = OP_MUL;
        default:    op = OP_INVALID;
      endcase
    end
  end

  always_comb begin
    alu_op    = ALU_ADD;
    alu_b     = rf_b;
    wb_sel    = WB_ALU;
    reg_write = 1'b0;
    mem_write = 1'b0;
    set_flags = 1'b0;
    rb_addr   = inst[20:16];
    case (op)
      OP_ADDI: begin alu_b = {52'd0, inst[21:10]}; reg_write = 1'b1; end
      OP_ADDS: begin reg_write = 1'b1; set_flags = 1'b1; end
      OP_SUBS: begin alu_op = ALU_SUB; reg_write = 1'b1; set_flags = 1'b1; end
      OP_LDUR: begin
        alu_b     = {{55{inst[20]}}, inst[20:12]};
        reg_write = 1'b1;
        wb_sel    = WB_MEM;
      end
      OP_STUR: begin
        alu_b     = {{55{inst[20]}}, inst[20:12]};
        mem_write = 1'b1;
        rb_addr   = inst[4:0];
      end
      OP_CBZ:  begin alu_op = ALU_PASSB; rb_addr = inst[4:0]; end
      OP_LSL,
      OP_LSR:  begin reg_write = 1'b1; wb_sel = WB_SHIFT; end
      OP_MUL:  begin reg_write = 1'b1; wb_sel = WB_MUL; end
      default: ;
    endcase
  end

  decode_exec_alu u_alu (
    .a      (rf_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // BLT tests the registered flags (n ^ v); CBZ tests the live ALU zero.
  always_comb begin
    case (op)
      OP_B:    br_taken = 1'b1;
      OP_BLT:  br_taken = flags_reg[3] ^ flags_reg[1];
      OP_CBZ:  br_taken = alu_flags[2];
      default: br_taken = 1'b0;
    endcase
  end

  assign off19 = {{43{inst[23]}}, inst[23:5], 2'b00};
  assign off26 = {{36{inst[25]}}, inst[25:0], 2'b00};

  always_comb begin
    pc_next    = pc_reg + 64'd4;
    flags_next = flags_reg;
    if (br_taken) pc_next = pc_reg + ((op == OP_B) ? off26 : off19);
    if (set_flags) flags_next = alu_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= 64'd0;
      flags_reg <= 4'd0;
    end else begin
      pc_reg    <= pc_next;
      flags_reg <= flags_next;
    end
  end

  assign pc         = pc_reg;
  assign flags      = flags_reg;
  assign opcode     = op;
  assign mem_to_reg = wb_sel;
  assign ra_addr    = inst[9:5];
  assign rd_addr    = inst[4:0];
  assign shamt      = inst[15:10];

`ifdef DECODE_EXEC_TRACE_EN
  always @(posedge clk) begin
    $display("decode_exec: op=%0d pc=%h next_pc=%h alu=%h flags=%b",
             opcode, pc_reg, pc_next, alu_result, flags_reg);
  end
`endif

endmodule

// File: tb/tb_decode_exec.sv
// tb_decode_exec -- directed bench for decode_exec. A behavioural model
// computes expected outputs from the instruction class chosen when each
// vector was encoded; a negedge compare process checks every output each
// cycle, and literal checks pin the hand-computed results.
module tb_decode_exec;

  localparam int C_INV = 0, C_ADDI = 1, C_ADDS = 2, C_BLT = 3, C_B = 4, C_CBZ = 5;
  localparam int C_LDUR = 6, C_LSL = 7, C_LSR = 8, C_MUL = 9, C_STUR = 10, C_SUBS = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [63:0] rf_a, rf_b;
  logic [63:0] pc;
  logic [3:0]  opcode;
  logic [4:0]  ra_addr, rb_addr, rd_addr;
  logic [5:0]  shamt;
  logic        reg_write, mem_write, br_taken;
  logic [1:0]  mem_to_reg;
  logic [63:0] alu_result;
  logic [3:0]  flags;

  decode_exec dut (
    .clk(clk), .rst(rst), .inst(inst), .rf_a(rf_a), .rf_b(rf_b),
    .pc(pc), .opcode(opcode), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .rd_addr(rd_addr), .shamt(shamt), .reg_write(reg_write),
    .mem_write(mem_write), .br_taken(br_taken), .mem_to_reg(mem_to_reg),
    .alu_result(alu_result), .flags(flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state and expected combinational outputs.
  logic [63:0] m_pc, m_pc_next;
  logic [3:0]  m_flags, m_flags_next;
  int          e_cls;
  logic [4:0]  e_ra, e_rb, e_rd;
  logic [5:0]  e_shamt;
  logic        e_rw, e_mw, e_br;
  logic [1:0]  e_m2r;
  logic [63:0] e_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Encoders
  function automatic logic [31:0] enc_r(input logic [10:0] opc, input logic [4:0] rm,
                                        input logic [5:0] sh, input logic [4:0] rn, input logic [4:0] rd);
    return {opc, rm, sh, rn, rd};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rn, input logic [4:0] rd);
    return {10'b1001000100, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] opc, input logic [8:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {opc, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction
  function automatic logic [31:0] enc_blt(input logic [18:0] imm);
    return {8'h54, imm, 5'b01011};
  endfunction
  function automatic logic [31:0] enc_cbz(input logic [18:0] imm, input logic [4:0] rt);
    return {8'hB4, imm, rt};
  endfunction

  // Drive one instruction and work out what the block must do with it.
  task automatic drive(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                       input int cls, input logic r);
    logic [63:0]        opb;
    longint             sx;
    longint             off;
    logic [64:0]        s;
    logic signed [64:0] w;
    bit                 is_sub;
    bit                 taken;
    rst = r; inst = i; rf_a = a; rf_b = b;
    e_cls   = cls;
    e_ra    = i[9:5];
    e_rd    = i[4:0];
    e_rb    = (cls == C_CBZ || cls == C_STUR) ? i[4:0] : i[20:16];
    e_shamt = i[15:10];
    if (cls == C_ADDI) opb = {52'd0, i[21:10]};
    else if (cls == C_LDUR || cls == C_STUR) begin
      sx  = $signed(i[20:12]);
      opb = sx;
    end else opb = b;
    is_sub = (cls == C_SUBS);
    if (is_sub) e_res = a - opb;
    else if (cls == C_CBZ) e_res = opb;
    else e_res = a + opb;
    taken = (cls == C_B) || (cls == C_BLT && (m_flags[3] != m_flags[1])) ||
            (cls == C_CBZ && e_res == 64'd0);
    if (cls == C_B) off = $signed(i[25:0]);
    else off = $signed(i[23:5]);
    m_pc_next = taken ? m_pc + off * 4 : m_pc + 64'd4;
    e_br  = taken;
    e_rw  = cls inside {C_ADDI, C_ADDS, C_SUBS, C_LDUR, C_LSL, C_LSR, C_MUL};
    e_mw  = (cls == C_STUR);
    e_m2r = (cls == C_LDUR) ? 2'd1 : (cls == C_MUL) ? 2'd2 :
            (cls == C_LSL || cls == C_LSR) ? 2'd3 : 2'd0;
    m_flags_next = m_flags;
    if (cls == C_ADDS || cls == C_SUBS) begin
      s = {1'b0, a} + {1'b0, opb};
      if (is_sub) w = $signed({a[63], a}) - $signed({opb[63], opb});
      else        w = $signed({a[63], a}) + $signed({opb[63], opb});
      m_flags_next = {e_res[63], e_res == 64'd0, w[64] ^ w[63], is_sub ? (a >= opb) : s[64]};
    end
    if (r) begin
      m_pc_next    = 64'd0;
      m_flags_next = 4'd0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_pc    = m_pc_next;
    m_flags = m_flags_next;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("opcode", 64'(opcode), 64'(e_cls));
      check("ra_addr", 64'(ra_addr), 64'(e_ra));
      check("rb_addr", 64'(rb_addr), 64'(e_rb));
      check("rd_addr", 64'(rd_addr), 64'(e_rd));
      check("shamt", 64'(shamt), 64'(e_shamt));
      check("reg_write", 64'(reg_write), 64'(e_rw));
      check("mem_write", 64'(mem_write), 64'(e_mw));
      check("br_taken", 64'(br_taken), 64'(e_br));
      check("mem_to_reg", 64'(mem_to_reg), 64'(e_m2r));
      check("alu_result", alu_result, e_res);
      check("pc", pc, m_pc);
      check("flags", 64'(flags), 64'(m_flags));
      $display("cycle t=%0t inst=%h cls=%0d pc=%h alu=%h flags=%b", $time, inst, opcode, pc, alu_result, flags);
    end
  end

  initial begin
    m_pc = 64'd0; m_flags = 4'd0;
    drive(32'd0, 64'd0, 64'd0, C_INV, 1'b1);
    tick();
    check("lit_reset_pc", pc, 64'd0);
    check("lit_reset_flags", 64'(flags), 64'd0);
    chk_en = 1'b1;

    drive(enc_r(11'b10101011000, 5'd2, 6'd0, 5'd1, 5'd3), 64'd5, 64'd7, C_ADDS, 1'b0);
    #1 check("lit_adds_alu", alu_result, 64'd12);
    tick();
    check("lit_adds_flags", 64'(flags), 64'h0);
    check("lit_adds_pc", pc, 64'h4);

    drive(enc_r(11'b11101011000, 5'd5, 6'd0, 5'd4, 5'd6), 64'd3, 64'd5, C_SUBS, 1'b0);
    #1 check("lit_subs_alu", alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check("lit_subs_flags", 64'(flags), 64'h8);

    drive(enc_blt(19'd2), 64'd0, 64'd0, C_BLT, 1'b0);
    #1 check("lit_blt_taken", 64'(br_taken), 64'd1);
    tick();
    check("lit_blt_pc", pc, 64'h10);

    drive(enc_cbz(19'd3, 5'd4), 64'd0, 64'd1, C_CBZ, 1'b0);
    tick();
    check("lit_cbz_nt_pc", pc, 64'h14);
    check("lit_cbz_nt_flags", 64'(flags), 64'h8);
    drive(enc_b(26'h3FFFFFF), 64'd0, 64'd0, C_B, 1'b0);
    tick();
    drive(enc_cbz(19'd3, 5'd4), 64'd0, 64'd0, C_CBZ, 1'b0);
    tick();
    check("lit_cbz_t_pc", pc, 64'h1C);

    drive(enc_b(26'h3FFFFFB), 64'd0, 64'd0, C_B, 1'b0);
    tick();
    drive(enc_b(26'h3FFFFFF), 64'd0, 64'd0, C_B, 1'b0);
    tick();
    check("lit_b_back_pc", pc, 64'h4);

    drive(enc_r(11'b10101011000, 5'd2, 6'd0, 5'd1, 5'd3), 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, C_ADDS, 1'b0);
    tick();
    check("lit_ovf_flags", 64'(flags), 64'hA);

    drive(enc_blt(19'd2), 64'd0, 64'd0, C_BLT, 1'b0);
    tick();
    drive(32'h0000_0000, 64'd9, 64'd9, C_INV, 1'b0);
    #1 check("lit_inv_rw", 64'({reg_write, mem_write}), 64'd0);
    tick();
    check("lit_inv_pc", pc, 64'h10);
    drive(32'hFFFF_FFFF, 64'd1, 64'd2, C_INV, 1'b0);
    tick();

    drive(enc_addi(12'hFFF, 5'd1, 5'd2), 64'd1, 64'd77, C_ADDI, 1'b0);
    #1 check("lit_addi_alu", alu_result, 64'h1000);
    tick();
    drive(enc_d(11'b11111000010, 9'h1F8, 5'd3, 5'd4), 64'h100, 64'd5, C_LDUR, 1'b0);
    #1 check("lit_ldur_alu", alu_result, 64'hF8);
    tick();
    drive(enc_d(11'b11111000000, 9'd16, 5'd3, 5'd7), 64'h200, 64'd5, C_STUR, 1'b0);
    tick();
    drive(enc_r(11'b11010011011, 5'd0, 6'd5, 5'd8, 5'd9), 64'd3, 64'd4, C_LSL, 1'b0);
    tick();
    drive(enc_r(11'b11010011010, 5'd1, 6'd63, 5'd8, 5'd9), 64'd3, 64'd4, C_LSR, 1'b0);
    tick();
    drive(enc_r(11'b10011011000, 5'd11, 6'd31, 5'd10, 5'd12), 64'd6, 64'd7, C_MUL, 1'b0);
    tick();

    drive(enc_r(11'b11101011000, 5'd2, 6'd0, 5'd1, 5'd3), 64'd9, 64'd9, C_SUBS, 1'b0);
    tick();
    check("lit_subs_eq_flags", 64'(flags), 64'h5);
    drive(enc_r(11'b11101011000, 5'd2, 6'd0, 5'd1, 5'd3), 64'h8000_0000_0000_0000, 64'd1, C_SUBS, 1'b0);
    tick();
    check("lit_subs_ovf_flags", 64'(flags), 64'h3);
    drive(enc_blt(19'h7FFFE), 64'd0, 64'd0, C_BLT, 1'b0);
    tick();

    // Reset in the middle of a taken branch and a flag-setting add.
    drive(enc_b(26'd100), 64'd0, 64'd0, C_B, 1'b1);
    tick();
    check("lit_midrst_pc", pc, 64'd0);
    check("lit_midrst_flags", 64'(flags), 64'd0);
    drive(enc_r(11'b10101011000, 5'd2, 6'd0, 5'd1, 5'd3), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, C_ADDS, 1'b1);
    tick();
    check("lit_rst_adds_flags", 64'(flags), 64'd0);
    drive(enc_r(11'b10101011000, 5'd2, 6'd0, 5'd1, 5'd3), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, C_ADDS, 1'b0);
    tick();
    check("lit_carry_flags", 64'(flags), 64'h5);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_exec.md
DECODE_EXEC -- requirements
Module: decode_exec

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 inst  input  32  current instruction word.
REQ-005 rf_a / rf_b  input  64 each  register-file read data for ra_addr / rb_addr.
REQ-006 pc  output  64  registered program counter.
REQ-007 opcode  output  4  decoded class: 0 invalid, 1 ADDI, 2 ADDS, 3 BLT, 4 B, 5 CBZ, 6 LDUR, 7 LSL, 8 LSR, 9 MUL, 10 STUR, 11 SUBS.
REQ-008 ra_addr, rb_addr, rd_addr  output  5 each  register addresses.
REQ-009 shamt  output  6  shift amount.
REQ-010 reg_write, mem_write, br_taken  output  1 each  control strobes.
REQ-011 mem_to_reg  output  2  writeback select: 0 ALU, 1 memory, 2 multiplier, 3 shifter.
REQ-012 alu_result  output  64  ALU result, also used as the memory address.
REQ-013 flags  output  4  registered {n,z,v,c}.

Function
REQ-014 Fields: Rd=inst[4:0], Rn=inst[9:5], Rm=inst[20:16], shamt=inst[15:10], imm12=inst[21:10], imm9=inst[20:12], imm19=inst[23:5], imm26=inst[25:0].
REQ-015 Decode: B when [31:26]=000101; BLT when [31:24]=01010100 and [4:0]=01011; CBZ when [31:24]=10110100; ADDI when [31:22]=1001000100.
REQ-016 11-bit decode on [31:21]: ADDS 10101011000, SUBS 11101011000, LDUR 11111000010, STUR 11111000000, LSL 11010011011, LSR 11010011010, MUL 10011011000.
REQ-017 Any other encoding SHALL give opcode 0 and act as a NOP: no register or memory write, pc+4, flags held.
REQ-018 ra_addr=Rn; rb_addr=Rd for CBZ and STUR, otherwise Rm; rd_addr=Rd.
REQ-019 ALU B operand: zero-extended imm12 for ADDI; sign-extended imm9 for LDUR/STUR; rf_b otherwise.
REQ-020 ALU operation: subtract for SUBS; pass-B for CBZ; add for all others; all arithmetic is 64-bit modulo 2^64.
REQ-021 ALU flags: n=result[63]; z=(result==0); c=carry out of bit 63, with subtract computed as A+~B+1 so c=1 means no borrow; v=signed overflow.
REQ-022 Only ADDS and SUBS SHALL load the flags register; all other instructions hold it.
REQ-023 reg_write=1 for ADDI, ADDS, SUBS, LDUR, LSL, LSR, MUL; mem_write=1 only for STUR.
REQ-024 br_taken=1 for B; for BLT when registered n^v=1; for CBZ when the ALU zero output is 1 in the same cycle.
REQ-025 Next pc = pc+4 when not taken; otherwise pc+(sext(imm26)<<2) for B, or pc+(sext(imm19)<<2) for BLT/CBZ, modulo 2^64.
REQ-026 All outputs except pc and flags SHALL be combinational from inst, rf_a, rf_b and state.

Reset
REQ-027 When rst=1 at a clock edge, pc and flags SHALL become 0 and take priority over any instruction.
REQ-028 Reset asserted mid-stream SHALL discard the pending branch or flag update.

Configuration
REQ-029 With macro DECODE_EXEC_TRACE_EN defined, each rising clk edge SHALL print opcode, pc, next pc, alu_result and flags with $display.
REQ-030 Without DECODE_EXEC_TRACE_EN, no simulation output SHALL be produced and the logic SHALL be unchanged.

Structure
REQ-031 A shared package SHALL hold the opcode-class constants, the ALU operation codes and the mem_to_reg select codes.
REQ-032 The 64-bit ALU SHALL be one sub-module, decode_exec_alu; decode, immediate extension and the PC adders SHALL live in the top module.

Verification
REQ-033 Reset: rst=1 for one edge -> pc=0, flags=0000.
REQ-034 ADDS with rf_a=5, rf_b=7 -> alu_result=12, after the edge flags=0000, pc=4.
REQ-035 SUBS with rf_a=3, rf_b=5 -> alu_result=0xFFFF_FFFF_FFFF_FFFE, flags n=1, c=0; a following BLT with imm19=2 at pc=8 -> br_taken=1, next pc=0x10.
REQ-036 CBZ with rf_b=0, imm19=3 at pc=0x10 -> next pc=0x1C; same with rf_b=1 -> next pc=0x14, flags unchanged.
REQ-037 B with imm26=0x3FFFFFF at pc=8 -> next pc=4.
REQ-038 ADDS with 0x7FFF_FFFF_FFFF_FFFF + 1 -> n=1, v=1, z=0, c=0; an invalid inst -> reg_write=0, mem_write=0, pc+4.
